adder4b_operand_fsm: RTL and testbench
======================================

// Module: adder4b_operand_fsm
// PURPOSE
//  Upstream stage of the seven-segment display path. It collects two 4-bit operands
//  from asynchronous DIP switches, confirming each with a push-button. It adds them
//  and presents a 4-bit digit, a carry and a decimal-point flag to the
//  seven-segment decoder. Operand entry is sequenced by a 4-state FSM; the button
//  is synchronised, edge-detected and debounced inside the block.
// PARAMETERS
//  WIDTH           4      operand/digit width in bits
//  SYNC_STAGES     2      flop stages on every asynchronous input (>=2)
//  DEBOUNCE_CYCLES 16     clocks after an accepted press during which presses are ignored
//  BLINK_DIV       8      dp toggles every BLINK_DIV clocks while in WAIT_B
// PORTS
//  clk           in   1      system clock; all logic on its rising edge
//  rst           in   1      asynchronous, active-low reset (0 = reset)
//  data_in       in   WIDTH  operand switches; asynchronous to clk
//  btn_in        in   1      enter button, active-high; asynchronous to clk
//  digit         out  WIDTH  value for the seven-segment decoder
//  carry         out  1      sum bit WIDTH; valid in SHOW only, else 0
//  dp            out  1      decimal point: blink in WAIT_B, 1 in SHOW, else 0
//  result_valid  out  1      1 only while in SHOW
//  state_o       out  2      FSM state code, for debug
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; operands, sum, counters and sync flops = 0;
//   digit=0, carry=0, dp=0, result_valid=0, state_o=2'b00. Takes effect mid-operation
//   with no clock; on release the FSM starts from IDLE.
//  Input conditioning: data_in and btn_in pass through SYNC_STAGES flops.
//   press = sync_btn & ~sync_btn_d (one-cycle pulse), gated by debounce.
//   Latency: btn_in rise -> press pulse visible SYNC_STAGES+1 cycles later.
//   Debounce: an accepted press loads a counter with DEBOUNCE_CYCLES-1. While the
//   counter is nonzero, edges are discarded; they are not queued.
//  FSM (registered, encoded IDLE=00, WAIT_B=01, ADD=10, SHOW=11):
//   IDLE   : digit = sync data; press -> op_a <= sync data, go WAIT_B.
//   WAIT_B : digit = sync data; dp toggles every BLINK_DIV clks, starting at 0 on
//            entry; press -> op_b <= sync data, go ADD.
//   ADD    : exactly 1 cycle; sum[WIDTH:0] <= op_a + op_b (zero-extended, no
//            saturation); go SHOW unconditionally; presses here are discarded.
//   SHOW   : digit = sum[WIDTH-1:0], carry = sum[WIDTH], dp = 1, result_valid = 1.
//            Press -> op_a <= sync data, go WAIT_B (chained entry; skips IDLE).
//  Press to result: result_valid rises 2 clks after the press pulse that captures B.
//  Outputs are registered; they change 1 clk after the state/data change.
//  The blink counter wraps at BLINK_DIV-1 -> 0 and is cleared whenever the FSM is
//   not in WAIT_B.
//  Simultaneous events: a data_in change in the press cycle captures the
//   synchronised value sampled that cycle. A press with the debounce counter
//   nonzero is ignored.
// STRUCTURE
//  Package adder4b_pkg: state typedef/localparams (IDLE, WAIT_B, ADD, SHOW),
//   WIDTH default, state code width.
//  Sub-module adder4b_btn_conditioner: synchroniser, edge detect and debounce
//   counter; outputs a 1-clk press pulse. It is instantiated once for the button.
//   data_in uses plain sync flops in the top.
//  The top holds the FSM, the operand/sum registers, the blink divider and the
//   output registers.
// TESTING
//  1 Reset: hold rst=0 with random inputs, then release -> all outputs 0, state_o=00.
//    Assert rst=0 mid-WAIT_B -> outputs clear immediately, with no clock edge.
//  2 Basic add: A=3 press, B=4 press -> result_valid=1, digit=7, carry=0, dp=1,
//    2 clks after press B is detected.
//  3 Overflow: A=15, B=15 -> digit=4'hE, carry=1. Then A=0, B=0 (chained from SHOW)
//    -> digit=0, carry=0.
//  4 Debounce: glitch btn 3 times within 10 clks -> exactly one state advance.
//    A second press after 16+ clks is accepted.
//  5 Blink: stay in WAIT_B for 40 clks -> dp toggles every 8 clks; leaving WAIT_B
//    clears dp on entry to ADD.
//  6 Latency: btn_in rise -> state_o changes exactly SYNC_STAGES+2 clks later.
//    A data_in change 1 clk before press capture is not taken; the prior value is.

Source files
------------

// File: rtl/adder4b_pkg.sv
// Shared types and constants for the operand-entry adder front end.
package adder4b_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 2'b00,
        StWaitB = 2'b01,
        StAdd   = 2'b10,
        StShow  = 2'b11
    } state_e;

endpackage

// File: rtl/adder4b_btn_conditioner.sv
// Button front end: synchroniser, rising-edge detector and debounce lockout.
// Emits a registered one-cycle press pulse.
module adder4b_btn_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_d_q;
    logic                   press_q;
    logic [CntW-1:0]        cnt_q;
    logic                   rise;
    logic                   accept;

    assign rise   = sync_q[SYNC_STAGES-1] & ~btn_d_q;
    // Edges seen during the lockout window are dropped, not queued.
    assign accept = rise && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            btn_d_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            btn_d_q <= sync_q[SYNC_STAGES-1];
            press_q <= accept;
            if (accept) begin
                cnt_q <= CntW'(DEBOUNCE_CYCLES - 1);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/adder4b_operand_fsm.sv
// Operand entry FSM: captures A and B from synchronised switches on button
// presses, adds them and drives registered display outputs.
module adder4b_operand_fsm
    import adder4b_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEF,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_DIV       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               btn_in,
    output logic [WIDTH-1:0]   digit,
    output logic               carry,
    output logic               dp,
    output logic               result_valid,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [WIDTH-1:0]  data_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  data_s;
    logic              press;
    state_e            state_q;
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;
    logic [WIDTH:0]    sum_q;
    logic [WIDTH:0]    add_res;
    logic [BlinkW-1:0] blink_q;
    logic [WIDTH-1:0]  digit_q;
    logic              carry_q;
    logic              dp_q;
    logic              valid_q;

    adder4b_btn_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (btn_in),
        .press_o (press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                data_sync_q[i] <= '0;
            end
        end else begin
            data_sync_q[0] <= data_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
        end
    end

    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign add_res = {1'b0, op_a_q} + {1'b0, op_b_q};

    // Outputs are assigned alongside the state transition so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            blink_q <= '0;
            digit_q <= '0;
            carry_q <= 1'b0;
            dp_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    digit_q <= data_s;
                    blink_q <= '0;
                    if (press) begin
                        op_a_q  <= data_s;
                        state_q <= StWaitB;
                    end
                end
                StWaitB: begin
                    digit_q <= data_s;
                    if (press) begin
                        op_b_q  <= data_s;
                        state_q <= StAdd;
                        blink_q <= '0;
                        dp_q    <= 1'b0;
                    end else if (blink_q == BlinkW'(BLINK_DIV - 1)) begin
                        blink_q <= '0;
                        dp_q    <= ~dp_q;
                    end else begin
                        blink_q <= blink_q + 1'b1;
                    end
                end
                StAdd: begin
                    sum_q   <= add_res;
                    state_q <= StShow;
                    digit_q <= add_res[WIDTH-1:0];
                    carry_q <= add_res[WIDTH];
                    dp_q    <= 1'b1;
                    valid_q <= 1'b1;
                end
                StShow: begin
                    if (press) begin
                        op_a_q  <= data_s;
                        state_q <= StWaitB;
                        digit_q <= data_s;
                        carry_q <= 1'b0;
                        dp_q    <= 1'b0;
                        valid_q <= 1'b0;
                        blink_q <= '0;
                    end else begin
                        digit_q <= sum_q[WIDTH-1:0];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign digit        = digit_q;
    assign carry        = carry_q;
    assign dp           = dp_q;
    assign result_valid = valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_adder4b_operand_fsm.sv
// Directed bench for adder4b_operand_fsm: table-driven add vectors plus
// hand-timed reset, debounce, blink and latency sequences.
module tb_adder4b_operand_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic       btn_in;
    logic [3:0] digit;
    logic       carry;
    logic       dp;
    logic       result_valid;
    logic [1:0] state_o;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] digit;
        logic       carry;
    } vec_t;

    vec_t vecs[6];

    adder4b_operand_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .btn_in       (btn_in),
        .digit        (digit),
        .carry        (carry),
        .dp           (dp),
        .result_valid (result_valid),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] v);
        data_in = v;
        cycles(3);
        @(negedge clk);
        btn_in = 1'b1;
        cycles(2);
        btn_in = 1'b0;
        cycles(20);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_digit"}, 32'(digit), 32'h0);
        check({tag, "_carry"}, 32'(carry), 32'h0);
        check({tag, "_dp"}, 32'(dp), 32'h0);
        check({tag, "_valid"}, 32'(result_valid), 32'h0);
        check({tag, "_state"}, 32'(state_o), 32'h0);
    endtask

    initial begin
        vecs[0] = '{a: 4'd3,  b: 4'd4,  digit: 4'd7,  carry: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, digit: 4'hE,  carry: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  digit: 4'd0,  carry: 1'b0};
        vecs[3] = '{a: 4'd9,  b: 4'd8,  digit: 4'd1,  carry: 1'b1};
        vecs[4] = '{a: 4'd8,  b: 4'd7,  digit: 4'hF,  carry: 1'b0};
        vecs[5] = '{a: 4'd1,  b: 4'd15, digit: 4'd0,  carry: 1'b1};

        // Reset held with random inputs, then released.
        rst     = 1'b0;
        data_in = 4'd0;
        btn_in  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            data_in = 4'($urandom);
            btn_in  = 1'($urandom);
        end
        @(negedge clk);
        btn_in  = 1'b0;
        data_in = 4'd0;
        rst     = 1'b1;
        #1;
        check_cleared("reset_release");
        cycles(20);
        check("idle_hold_state", 32'(state_o), 32'h0);

        // Add vectors; the first starts in IDLE, the rest chain from SHOW.
        for (int i = 0; i < 6; i++) begin
            enter(vecs[i].a);
            check($sformatf("vec%0d_waitb_state", i), 32'(state_o), 32'h1);
            enter(vecs[i].b);
            check($sformatf("vec%0d_digit", i), 32'(digit), 32'(vecs[i].digit));
            check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].carry));
            check($sformatf("vec%0d_dp", i), 32'(dp), 32'h1);
            check($sformatf("vec%0d_valid", i), 32'(result_valid), 32'h1);
            check($sformatf("vec%0d_state", i), 32'(state_o), 32'h3);
        end

        // WAIT_B tracks the switches, then async reset mid-operation.
        enter(4'd5);
        data_in = 4'd10;
        cycles(4);
        check("waitb_digit_follow", 32'(digit), 32'hA);
        check("waitb_carry", 32'(carry), 32'h0);
        check("waitb_valid", 32'(result_valid), 32'h0);
        data_in = 4'd0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_reset");
        @(negedge clk);
        rst = 1'b1;
        cycles(5);

        // Debounce: three glitches inside 10 clocks advance the FSM once.
        data_in = 4'd2;
        cycles(3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            btn_in = 1'b1;
            @(negedge clk);
            btn_in = 1'b0;
            cycles(1);
        end
        cycles(25);
        check("debounce_one_advance", 32'(state_o), 32'h1);
        enter(4'd4);
        check("debounce_second_press", 32'(state_o), 32'h3);
        check("debounce_sum", 32'(digit), 32'h6);

        // Latency from SHOW (chained entry) and dp blink in WAIT_B.
        data_in = 4'd1;
        cycles(3);
        @(negedge clk);
        btn_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) btn_in = 1'b0;
            check($sformatf("latency_pre_edge%0d", k), 32'(state_o), 32'h3);
        end
        @(negedge clk);
        check("latency_state_change", 32'(state_o), 32'h1);
        check("blink_dp_k0", 32'(dp), 32'h0);
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("blink_dp_k%0d", k), 32'(dp), 32'((k / 8) % 2));
        end

        // B capture with a late switch change, then ADD and SHOW timing.
        data_in = 4'd9;
        cycles(3);
        @(negedge clk);
        btn_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        btn_in = 1'b0;
        @(negedge clk);
        data_in = 4'd2;
        @(negedge clk);
        check("add_state", 32'(state_o), 32'h2);
        check("add_dp_cleared", 32'(dp), 32'h0);
        check("add_valid_low", 32'(result_valid), 32'h0);
        @(negedge clk);
        check("show_state", 32'(state_o), 32'h3);
        check("show_valid", 32'(result_valid), 32'h1);
        check("show_digit_prior_data", 32'(digit), 32'hA);
        check("show_carry", 32'(carry), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
